// File: rtl/bs_4_mux81.sv
//==========================================================================
// bs_4_mux81 : registered 8-to-1 bus-select mux (WIDTH-bit words).
// Optional macro BS_MUX_PARITY_EN adds registered parity output `par`.
// Revision  : 1.0
//==========================================================================
`default_nettype none

module bs_4_mux81 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] data,
`ifdef BS_MUX_PARITY_EN
   output logic             par,
`endif
   input  logic [2:0]       s,
   input  logic [WIDTH-1:0] A0,
   input  logic [WIDTH-1:0] A1,
   input  logic [WIDTH-1:0] A2,
   input  logic [WIDTH-1:0] A3,
   input  logic [WIDTH-1:0] A4,
   input  logic [WIDTH-1:0] A5,
   input  logic [WIDTH-1:0] A6,
   input  logic [WIDTH-1:0] A7
);

   logic [WIDTH-1:0] w_words [8];
   logic [WIDTH-1:0] w_sel_word;
   logic [WIDTH-1:0] r_data;

   assign w_words[0] = A0;
   assign w_words[1] = A1;
   assign w_words[2] = A2;
   assign w_words[3] = A3;
   assign w_words[4] = A4;
   assign w_words[5] = A5;
   assign w_words[6] = A6;
   assign w_words[7] = A7;

   // Every 3-bit code is a legal index; an X select propagates X in simulation.
   always_comb begin
      w_sel_word = w_words[s];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
      end else begin
         r_data <= w_sel_word;
      end
   end

   assign data = r_data;

`ifdef BS_MUX_PARITY_EN
   logic r_par;

   // Parity is taken from the same word loaded into r_data so both stay aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par <= 1'b0;
      end else begin
         r_par <= ^w_sel_word;
      end
   end

   assign par = r_par;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bs_4_mux81.sv
//==========================================================================
// tb_bs_4_mux81 : directed self-checking bench for bs_4_mux81.
// Revision      : 1.0
//==========================================================================
`default_nettype none

module tb_bs_4_mux81;

   logic       clk;
   logic       rst;
   logic [3:0] data;
   logic [2:0] s;
   logic [3:0] A0, A1, A2, A3, A4, A5, A6, A7;
`ifdef BS_MUX_PARITY_EN
   logic       par;
`endif

   int n_cmp;
   int n_fail;

   logic [3:0] exp_sweep [8];
   logic       exp_par   [8];

   bs_4_mux81 #(.WIDTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .data (data),
`ifdef BS_MUX_PARITY_EN
      .par  (par),
`endif
      .s    (s),
      .A0   (A0),
      .A1   (A1),
      .A2   (A2),
      .A3   (A3),
      .A4   (A4),
      .A5   (A5),
      .A6   (A6),
      .A7   (A7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench timed out");
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_par(input string tag, input logic exp);
`ifdef BS_MUX_PARITY_EN
      n_cmp++;
      assert (par === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, par, exp);
      end
`endif
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      exp_sweep = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b1100, 4'b1110, 4'b0111, 4'b1111};
      exp_par   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      s   = 3'b000;
      A0 = 4'b0001; A1 = 4'b0010; A2 = 4'b0100; A3 = 4'b1000;
      A4 = 4'b1100; A5 = 4'b1110; A6 = 4'b0111; A7 = 4'b1111;

      // Reset state, held across a clock edge
      @(posedge clk); #1;
      check("reset_hold", data, 4'b0000);
      check_par("reset_par", 1'b0);

      // Load A5 then assert reset between edges
      @(negedge clk);
      rst = 1'b0;
      s   = 3'b101;
      @(posedge clk); #1;
      check("load_a5", data, 4'b1110);
      check_par("par_a5", 1'b1);
      #1 rst = 1'b1;
      #1;
      check("async_reset", data, 4'b0000);
      check_par("async_reset_par", 1'b0);
      @(posedge clk); #1;
      check("reset_stays", data, 4'b0000);
      @(negedge clk);
      rst = 1'b0;

      // Full select sweep with mid-operation reset at s=6
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         s = 3'(i);
         @(posedge clk); #1;
         check($sformatf("sweep_s%0d", i), data, exp_sweep[i]);
         check_par($sformatf("sweep_par_s%0d", i), exp_par[i]);
         if (i == 6) begin
            rst = 1'b1;
            #1;
            check("midop_reset", data, 4'b0000);
            #1 rst = 1'b0;
            #1;
            check("midop_reset_released", data, 4'b0000);
            @(posedge clk); #1;
            check("midop_restore", data, 4'b0111);
         end
      end

      // Latency: change s just after an edge
      @(negedge clk);
      s = 3'b000;
      @(posedge clk); #1;
      check("lat_base", data, 4'b0001);
      s = 3'b111;
      #1;
      check("lat_hold_early", data, 4'b0001);
      @(negedge clk);
      check("lat_hold_neg", data, 4'b0001);
      @(posedge clk); #1;
      check("lat_update", data, 4'b1111);

      // Input-change tracking on the selected word only
      @(negedge clk);
      s = 3'b010;
      @(posedge clk); #1;
      check("track_base", data, 4'b0100);
      @(negedge clk);
      A2 = 4'b1010;
      @(posedge clk); #1;
      check("track_a2", data, 4'b1010);
      @(negedge clk);
      A0 = 4'b1111; A1 = 4'b0000; A3 = 4'b0101; A4 = 4'b0011;
      A5 = 4'b1001; A6 = 4'b0110; A7 = 4'b0000;
      @(posedge clk); #1;
      check("track_others", data, 4'b1010);

      // Simultaneous change of s and inputs
      @(negedge clk);
      s  = 3'b100;
      A4 = 4'b1011;
      @(posedge clk); #1;
      check("simul_change", data, 4'b1011);
      check_par("simul_par", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
